maze_game_seq: RTL

Game-flow sequencer for the 8x8 LED-matrix maze. It owns the player position and the level/crash/win state, and validates every keypad step against the map ROM through a request/valid read port. It drives the 2-bit map page select, i.e. the upper address bits of the map ROM, for the display scanner. It sits between the debounced keypad decoder (upstream) and the map ROM / row-mix datapath (downstream).

---
 rtl/maze_game_seq.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/maze_game_seq.sv
// maze_game_seq: game-flow sequencer for the 8x8 LED-matrix maze.
// Owns player position, level, crash/win state and step validation
// against the map ROM through a one-cycle request / rd_valid response port.
//
// Ports:
//   i_clk        system clock (divided scan clock)
//   i_rst_n      asynchronous active-low reset
//   i_frame_tick one-cycle strobe per display frame
//   i_step_en    one-cycle debounced key-press strobe
//   i_dir        00 up (y-1), 01 down (y+1), 10 left (x+1), 11 right (x-1)
//   i_rd_wall    map bit at requested cell
//   i_rd_valid   i_rd_wall is valid this cycle
//   o_rd_req     one-cycle map read request
//   o_rd_x/y     requested cell, held until the next request
//   o_rd_page    requested map page
//   o_map_sel    display page: 00 level1, 01 crash, 10 level2, 11 win
//   o_pos_x/y    player position
//   o_player_on  red player dot enabled
//   o_busy       step in flight
//   o_move_cnt   steps committed in current level, saturating at 255
//
// Optional feature: define MAZE_MOVE_LIMIT_EN to crash on the commit that
// brings o_move_cnt to MOVE_LIMIT (goal entry is never blocked).
module maze_game_seq #(
    parameter int START_X    = 1,
    parameter int START_Y    = 0,
    parameter int GOAL1_X    = 0,
    parameter int GOAL1_Y    = 6,
    parameter int L2_START_X = 6,
    parameter int L2_START_Y = 5,
    parameter int EXIT_X     = 0,
    parameter int EXIT_Y     = 6,
    parameter int CRASH_HOLD = 8,
    parameter int MOVE_LIMIT = 40
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_frame_tick,
    input  logic       i_step_en,
    input  logic [1:0] i_dir,
    input  logic       i_rd_wall,
    input  logic       i_rd_valid,
    output logic       o_rd_req,
    output logic [2:0] o_rd_x,
    output logic [2:0] o_rd_y,
    output logic [1:0] o_rd_page,
    output logic [1:0] o_map_sel,
    output logic [2:0] o_pos_x,
    output logic [2:0] o_pos_y,
    output logic       o_player_on,
    output logic       o_busy,
    output logic [7:0] o_move_cnt
);
    typedef enum logic [1:0] {S_PLAY, S_CHECK, S_CRASH, S_WIN} state_t;

    state_t     r_state, w_state;
    logic       r_level, w_level;
    logic [2:0] r_pos_x, r_pos_y, w_pos_x, w_pos_y;
    logic       r_rd_req, w_rd_req;
    logic [2:0] r_rd_x, r_rd_y, w_rd_x, w_rd_y;
    logic [1:0] r_rd_page, w_rd_page;
    logic [7:0] r_move_cnt, w_move_cnt;
    logic [7:0] r_hold, w_hold;

    logic [3:0] w_cx, w_cy;
    logic       w_oob, w_goal, w_limit;
    logic [7:0] w_cnt_inc, w_hold_inc;

    // 4-bit candidate: stepping past 0 or 7 sets bit 3, flagging a wrap
    assign w_cx = {1'b0, r_pos_x} + ((i_dir == 2'b10) ? 4'd1 : 4'd0) - ((i_dir == 2'b11) ? 4'd1 : 4'd0);
    assign w_cy = {1'b0, r_pos_y} + ((i_dir == 2'b01) ? 4'd1 : 4'd0) - ((i_dir == 2'b00) ? 4'd1 : 4'd0);
    assign w_oob = w_cx[3] | w_cy[3];
    // the held request address is the candidate under test
    assign w_goal = r_level ? (r_rd_x == 3'(EXIT_X) && r_rd_y == 3'(EXIT_Y))
                            : (r_rd_x == 3'(GOAL1_X) && r_rd_y == 3'(GOAL1_Y));
    assign w_cnt_inc  = (r_move_cnt == 8'hFF) ? r_move_cnt : r_move_cnt + 8'd1;
    assign w_hold_inc = r_hold + 8'd1;
`ifdef MAZE_MOVE_LIMIT_EN
    assign w_limit = (w_cnt_inc == 8'(MOVE_LIMIT));
`else
    assign w_limit = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_PLAY;
            r_level    <= 1'b0;
            r_pos_x    <= 3'(START_X);
            r_pos_y    <= 3'(START_Y);
            r_rd_req   <= 1'b0;
            r_rd_x     <= 3'd0;
            r_rd_y     <= 3'd0;
            r_rd_page  <= 2'b00;
            r_move_cnt <= 8'd0;
            r_hold     <= 8'd0;
        end else begin
            r_state    <= w_state;
            r_level    <= w_level;
            r_pos_x    <= w_pos_x;
            r_pos_y    <= w_pos_y;
            r_rd_req   <= w_rd_req;
            r_rd_x     <= w_rd_x;
            r_rd_y     <= w_rd_y;
            r_rd_page  <= w_rd_page;
            r_move_cnt <= w_move_cnt;
            r_hold     <= w_hold;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_level    = r_level;
        w_pos_x    = r_pos_x;
        w_pos_y    = r_pos_y;
        w_rd_req   = 1'b0;
        w_rd_x     = r_rd_x;
        w_rd_y     = r_rd_y;
        w_rd_page  = r_rd_page;
        w_move_cnt = r_move_cnt;
        w_hold     = r_hold;
        case (r_state)
            S_PLAY: begin
                if (i_step_en && w_oob) begin
                    w_state = S_CRASH;
                    w_hold  = 8'd0;
                end else if (i_step_en) begin
                    w_state   = S_CHECK;
                    w_rd_req  = 1'b1;
                    w_rd_x    = w_cx[2:0];
                    w_rd_y    = w_cy[2:0];
                    w_rd_page = {r_level, 1'b0};
                end
            end
            S_CHECK: begin
                if (i_rd_valid && w_goal && !r_level) begin
                    w_state    = S_PLAY;
                    w_level    = 1'b1;
                    w_pos_x    = 3'(L2_START_X);
                    w_pos_y    = 3'(L2_START_Y);
                    w_move_cnt = 8'd0;
                end else if (i_rd_valid && w_goal) begin
                    w_state = S_WIN;
                end else if (i_rd_valid && i_rd_wall) begin
                    w_state = S_CRASH;
                    w_hold  = 8'd0;
                end else if (i_rd_valid) begin
                    w_pos_x    = r_rd_x;
                    w_pos_y    = r_rd_y;
                    w_move_cnt = w_cnt_inc;
                    w_state    = w_limit ? S_CRASH : S_PLAY;
                    w_hold     = 8'd0;
                end
            end
            S_CRASH: begin
                if (i_frame_tick) w_hold = w_hold_inc;
                // restart on the tick that brings the hold count to CRASH_HOLD
                if (i_frame_tick && CRASH_HOLD != 0 && w_hold_inc == 8'(CRASH_HOLD)) begin
                    w_state    = S_PLAY;
                    w_level    = 1'b0;
                    w_pos_x    = 3'(START_X);
                    w_pos_y    = 3'(START_Y);
                    w_move_cnt = 8'd0;
                    w_hold     = 8'd0;
                end
            end
            default: ;
        endcase
    end

    assign o_rd_req    = r_rd_req;
    assign o_rd_x      = r_rd_x;
    assign o_rd_y      = r_rd_y;
    assign o_rd_page   = r_rd_page;
    assign o_map_sel   = (r_state == S_CRASH) ? 2'b01 : (r_state == S_WIN) ? 2'b11 : {r_level, 1'b0};
    assign o_pos_x     = r_pos_x;
    assign o_pos_y     = r_pos_y;
    assign o_player_on = (r_state == S_PLAY) || (r_state == S_CHECK);
    assign o_busy      = (r_state == S_CHECK);
    assign o_move_cnt  = r_move_cnt;
endmodule
